// File: rtl/riscv_wb_commit.sv
// riscv_wb_commit: writeback result select, registered RF write port, retire counter
// and trap/return redirect FSM that waits out icache stalls before a one-cycle flush.
module riscv_wb_commit #(
  parameter int XLEN = 64,
  parameter int NSRC = 5,
  localparam int SELW = $clog2(NSRC)
) (
  input  logic                 i_riscv_clk,
  input  logic                 i_riscv_rst_n,
  input  logic                 i_riscv_wb_valid,
  input  logic [SELW-1:0]      i_riscv_wb_resultsrc,
  input  logic [NSRC*XLEN-1:0] i_riscv_wb_srcdata,
  input  logic [XLEN-1:0]      i_riscv_wb_csrout,
  input  logic                 i_riscv_wb_iscsr,
  input  logic                 i_riscv_wb_regwrite,
  input  logic [4:0]           i_riscv_wb_rdaddr,
  input  logic                 i_riscv_wb_gototrap,
  input  logic [1:0]           i_riscv_wb_returnfromtrap,
  input  logic                 i_riscv_wb_icache_stall,
  output logic [XLEN-1:0]      o_riscv_wb_rddata,
  output logic [4:0]           o_riscv_wb_rdaddr,
  output logic                 o_riscv_wb_regwrite,
  output logic [1:0]           o_riscv_wb_pcsel,
  output logic                 o_riscv_wb_flush,
  output logic [XLEN-1:0]      o_riscv_wb_instret,
  output logic                 o_riscv_wb_busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE} state_t;
  localparam logic [SELW:0] NSRC_W = NSRC[SELW:0];
  state_t          r_state, w_next;
  logic [1:0]      r_pend_sel;
  logic [XLEN-1:0] r_rddata, r_instret;
  logic [4:0]      r_rdaddr;
  logic            r_regwrite;
  logic [XLEN-1:0] w_src [NSRC];
  logic [XLEN-1:0] w_data;
  logic            w_commit, w_ret, w_event, w_write;
  logic [1:0]      w_code;
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    assign w_src[k] = i_riscv_wb_srcdata[k*XLEN +: XLEN];
  end
  assign w_data   = i_riscv_wb_iscsr ? i_riscv_wb_csrout :
                    ({1'b0, i_riscv_wb_resultsrc} < NSRC_W) ? w_src[i_riscv_wb_resultsrc] : '0;
  assign w_commit = i_riscv_wb_valid & (r_state == S_IDLE);
  assign w_ret    = (i_riscv_wb_returnfromtrap == 2'b01) | (i_riscv_wb_returnfromtrap == 2'b10);
  assign w_event  = w_commit & (i_riscv_wb_gototrap | w_ret);
  assign w_write  = w_commit & i_riscv_wb_regwrite & ~i_riscv_wb_gototrap & (i_riscv_wb_rdaddr != 5'd0);
  // trap wins over a simultaneous return
  assign w_code   = i_riscv_wb_gototrap ? 2'b01 : (i_riscv_wb_returnfromtrap == 2'b01) ? 2'b10 : 2'b11;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_event ? (i_riscv_wb_icache_stall ? S_WAIT : S_FIRE) : S_IDLE;
      S_WAIT:  w_next = i_riscv_wb_icache_stall ? S_WAIT : S_FIRE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_riscv_clk or negedge i_riscv_rst_n) begin
    if (!i_riscv_rst_n) begin
      r_state    <= S_IDLE;
      r_pend_sel <= 2'b00;
      r_rddata   <= '0;
      r_rdaddr   <= 5'd0;
      r_regwrite <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_state    <= w_next;
      r_regwrite <= w_write;
      if (w_event) r_pend_sel <= w_code;
      if (w_write) begin
        r_rddata <= w_data;
        r_rdaddr <= i_riscv_wb_rdaddr;
      end
      if (w_commit & ~i_riscv_wb_gototrap) r_instret <= r_instret + 1'b1;
    end
  end
  assign o_riscv_wb_rddata   = r_rddata;
  assign o_riscv_wb_rdaddr   = r_rdaddr;
  assign o_riscv_wb_regwrite = r_regwrite;
  assign o_riscv_wb_instret  = r_instret;
  assign o_riscv_wb_flush    = r_state == S_FIRE;
  assign o_riscv_wb_pcsel    = (r_state == S_FIRE) ? r_pend_sel : 2'b00;
  assign o_riscv_wb_busy     = r_state != S_IDLE;
endmodule

// File: tb/tb_riscv_wb_commit.sv
// tb_riscv_wb_commit: directed and random stimulus against a behavioural model;
// a second 8-bit instance exercises retire-counter wraparound in reachable time.
module tb_riscv_wb_commit;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         valid = 0, iscsr = 0, regwrite = 0, trap = 0, stall = 0;
  logic [2:0]   sel = 0;
  logic [319:0] src = '0;
  logic [63:0]  csr = '0;
  logic [4:0]   rd = 0;
  logic [1:0]   rft = 0;
  logic [39:0]  src8 = '0;
  logic [7:0]   csr8 = '0;
  logic [63:0]  o_rddata, o_instret;
  logic [4:0]   o_rdaddr, o_rdaddr8;
  logic         o_regwrite, o_flush, o_busy, o_regwrite8, o_flush8, o_busy8;
  logic [1:0]   o_pcsel, o_pcsel8;
  logic [7:0]   o_rddata8, o_instret8;
  int checks = 0, failures = 0;
  logic [63:0] m_rddata, m_instret;
  logic [4:0]  m_rdaddr;
  logic        m_we;
  int          m_wait, m_fire;

  always #5 clk = ~clk;

  riscv_wb_commit dut (
    .i_riscv_clk(clk), .i_riscv_rst_n(rst_n), .i_riscv_wb_valid(valid),
    .i_riscv_wb_resultsrc(sel), .i_riscv_wb_srcdata(src), .i_riscv_wb_csrout(csr),
    .i_riscv_wb_iscsr(iscsr), .i_riscv_wb_regwrite(regwrite), .i_riscv_wb_rdaddr(rd),
    .i_riscv_wb_gototrap(trap), .i_riscv_wb_returnfromtrap(rft),
    .i_riscv_wb_icache_stall(stall), .o_riscv_wb_rddata(o_rddata),
    .o_riscv_wb_rdaddr(o_rdaddr), .o_riscv_wb_regwrite(o_regwrite),
    .o_riscv_wb_pcsel(o_pcsel), .o_riscv_wb_flush(o_flush),
    .o_riscv_wb_instret(o_instret), .o_riscv_wb_busy(o_busy));

  riscv_wb_commit #(.XLEN(8)) dut8 (
    .i_riscv_clk(clk), .i_riscv_rst_n(rst_n), .i_riscv_wb_valid(valid),
    .i_riscv_wb_resultsrc(sel), .i_riscv_wb_srcdata(src8), .i_riscv_wb_csrout(csr8),
    .i_riscv_wb_iscsr(iscsr), .i_riscv_wb_regwrite(regwrite), .i_riscv_wb_rdaddr(rd),
    .i_riscv_wb_gototrap(trap), .i_riscv_wb_returnfromtrap(rft),
    .i_riscv_wb_icache_stall(stall), .o_riscv_wb_rddata(o_rddata8),
    .o_riscv_wb_rdaddr(o_rdaddr8), .o_riscv_wb_regwrite(o_regwrite8),
    .o_riscv_wb_pcsel(o_pcsel8), .o_riscv_wb_flush(o_flush8),
    .o_riscv_wb_instret(o_instret8), .o_riscv_wb_busy(o_busy8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rddata = '0; m_instret = '0; m_rdaddr = '0; m_we = 0; m_wait = 0; m_fire = 0;
  endtask

  // One clock of the specified behaviour, using the inputs present at the edge
  task automatic model_step();
    bit commit;
    bit ret;
    int code;
    logic [63:0] data;
    commit = valid && m_wait == 0 && m_fire == 0;
    ret = (rft == 2'b01) || (rft == 2'b10);
    code = trap ? 1 : (rft == 2'b01 ? 2 : 3);
    if (m_fire != 0) m_fire = 0;
    else if (m_wait != 0) begin
      if (!stall) begin m_fire = m_wait; m_wait = 0; end
    end else if (commit && (trap || ret)) begin
      if (stall) m_wait = code; else m_fire = code;
    end
    data = iscsr ? csr : (sel < 5 ? src[sel*64 +: 64] : 64'd0);
    m_we = commit && regwrite && !trap && rd != 0;
    if (m_we) begin m_rddata = data; m_rdaddr = rd; end
    if (commit && !trap) m_instret = m_instret + 1;
  endtask

  task automatic check_all();
    chk("rddata", o_rddata, m_rddata);
    chk("rdaddr", 64'(o_rdaddr), 64'(m_rdaddr));
    chk("regwrite", 64'(o_regwrite), 64'(m_we));
    chk("pcsel", 64'(o_pcsel), 64'(m_fire));
    chk("flush", 64'(o_flush), 64'(m_fire != 0));
    chk("busy", 64'(o_busy), 64'(m_wait != 0 || m_fire != 0));
    chk("instret", o_instret, m_instret);
    chk("instret8", 64'(o_instret8), 64'(m_instret[7:0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic idle_inputs();
    valid = 0; iscsr = 0; regwrite = 0; trap = 0; stall = 0; rft = 0; sel = 0; rd = 0;
  endtask

  initial begin
    model_reset();
    #1 check_all();
    @(negedge clk) rst_n = 1;
    step();
    // source select
    valid = 1; regwrite = 1; rd = 7; sel = 2; src[128 +: 64] = 64'hDEAD;
    step();
    chk("src2_data", o_rddata, 64'hDEAD);
    chk("src2_instret", o_instret, 64'd1);
    iscsr = 1; csr = 64'h55;
    step();
    chk("csr_data", o_rddata, 64'h55);
    // x0 write suppressed, still retires
    rd = 0;
    step();
    chk("x0_regwrite", 64'(o_regwrite), 64'd0);
    chk("x0_instret", o_instret, 64'd3);
    iscsr = 0; sel = 6; rd = 3;
    step();
    chk("oor_data", o_rddata, 64'd0);
    // trap without stall; the instruction in the FIRE cycle must not commit
    trap = 1;
    step();
    chk("trap_flush", 64'(o_flush), 64'd1);
    chk("trap_pcsel", 64'(o_pcsel), 64'd1);
    chk("trap_instret", o_instret, 64'd4);
    trap = 0; sel = 1; rd = 9;
    step();
    chk("fire_nocommit", 64'(o_regwrite), 64'd0);
    chk("trap_flush_end", 64'(o_flush), 64'd0);
    // sret under a 3-cycle stall
    rft = 2'b10; stall = 1; valid = 1; regwrite = 0;
    step();
    rft = 0; valid = 0;
    step();
    step();
    chk("stall_busy", 64'(o_busy), 64'd1);
    chk("stall_noflush", 64'(o_flush), 64'd0);
    stall = 0;
    step();
    chk("sret_flush", 64'(o_flush), 64'd1);
    chk("sret_pcsel", 64'(o_pcsel), 64'd3);
    step();
    // trap beats mret
    valid = 1; trap = 1; rft = 2'b01;
    step();
    chk("prio_pcsel", 64'(o_pcsel), 64'd1);
    idle_inputs();
    step();
    // async reset while waiting aborts the redirect
    valid = 1; trap = 1; stall = 1;
    step();
    chk("wait_busy", 64'(o_busy), 64'd1);
    trap = 0; valid = 0;
    #2 rst_n = 0;
    model_reset();
    #1 check_all();
    chk("rst_busy", 64'(o_busy), 64'd0);
    @(negedge clk) rst_n = 1; stall = 0;
    repeat (3) step();
    // random traffic; the 8-bit instance wraps its counter along the way
    for (int i = 0; i < 1200; i++) begin
      valid = $urandom_range(0, 7) != 0;
      regwrite = $urandom_range(0, 3) != 0;
      iscsr = $urandom_range(0, 3) == 0;
      sel = 3'($urandom_range(0, 7));
      rd = 5'($urandom);
      trap = $urandom_range(0, 15) == 0;
      rft = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      stall = $urandom_range(0, 2) == 0;
      for (int k = 0; k < 5; k++) src[k*64 +: 64] = {$urandom, $urandom};
      csr = {$urandom, $urandom};
      src8 = 40'({$urandom, $urandom});
      csr8 = 8'($urandom);
      step();
    end
    chk("wrapped", 64'(m_instret > 64'd255), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_wb_commit.md
# riscv_wb_commit

Parametrised writeback/commit stage for the RV64 core. It selects the register-file write data from NSRC result sources plus the CSR read value and registers the write port. A trap/return redirect state machine holds a redirect while the instruction cache is stalled and then issues a one-cycle flush. It also keeps a retired-instruction counter and suppresses commits from younger instructions between a trap event and its redirect.

## Interface
Parameters:
- XLEN, 64, datapath width.
- NSRC, 5, number of result sources (NSRC ≥ 2).
- SELW, $clog2(NSRC), result-select width (derived, not overridden).

Ports:
- i_riscv_clk  in  1  core clock; all state on the rising edge.
- i_riscv_rst_n  in  1  reset, asynchronous assert, active-low.
- i_riscv_wb_valid  in  1  the WB-stage instruction is valid this cycle.
- i_riscv_wb_resultsrc  in  SELW  result-source select.
- i_riscv_wb_srcdata  in  NSRC*XLEN  flattened sources; source k is at [k*XLEN +: XLEN].
- i_riscv_wb_csrout  in  XLEN  CSR read data.
- i_riscv_wb_iscsr  in  1  selects csrout over the source mux.
- i_riscv_wb_regwrite  in  1  the instruction writes rd.
- i_riscv_wb_rdaddr  in  5  destination register.
- i_riscv_wb_gototrap  in  1  trap taken by this instruction.
- i_riscv_wb_returnfromtrap  in  2  01 = mret, 10 = sret, 00/11 = none.
- i_riscv_wb_icache_stall  in  1  instruction cache busy; a redirect must not issue.
- o_riscv_wb_rddata  out  XLEN  registered write data.
- o_riscv_wb_rdaddr  out  5  registered destination.
- o_riscv_wb_regwrite  out  1  registered write enable; never asserted for x0.
- o_riscv_wb_pcsel  out  2  00 = normal, 01 = trap vector, 10 = mepc, 11 = sepc.
- o_riscv_wb_flush  out  1  pipeline flush, one-cycle pulse.
- o_riscv_wb_instret  out  XLEN  retired-instruction count.
- o_riscv_wb_busy  out  1  a redirect is pending or firing (state ≠ IDLE).

## Operation
- **Data select:** if iscsr = 1, data = csrout. Otherwise data = srcdata[resultsrc]. If resultsrc ≥ NSRC, data = 0.
- **Commit condition:** valid & state == IDLE.
- **Write condition:** commit & regwrite & !gototrap & (rdaddr ≠ 0).
  - When true, the next edge loads rddata/rdaddr and sets regwrite = 1.
  - Otherwise regwrite = 0 and rddata/rdaddr hold their previous values.
- **Retire counter:** instret increments by 1 on commit & !gototrap.
  - mret/sret instructions do retire.
  - The counter wraps from 2^XLEN−1 to 0.
- **Event:** event = commit & (gototrap | returnfromtrap ∈ {01, 10}).
  - gototrap has priority over a simultaneous return.
  - Redirect code: trap → 01, mret → 10, sret → 11.
  - The code is latched into pend_sel when the event occurs.
- **Redirect FSM states:** IDLE, WAIT, FIRE.
  - IDLE: event & icache_stall → WAIT; event & !icache_stall → FIRE; otherwise stay in IDLE.
  - WAIT: stay while icache_stall = 1; go to FIRE when icache_stall = 0. Inputs are ignored (commits are blocked).
  - FIRE: flush = 1 and pcsel = pend_sel for exactly this cycle, then go to IDLE unconditionally. Inputs are ignored.
- **Outputs outside FIRE:** pcsel = 00, flush = 0. Both are decoded from registered state and pend_sel, with no combinational input-to-output path.

## Timing
- **Reset (async, rst_n low):**
  - rddata = 0, rdaddr = 0, regwrite = 0.
  - pcsel = 00, flush = 0, instret = 0, busy = 0.
  - state = IDLE, pend_sel = 00.
- **Write-port latency:** one cycle from WB inputs to o_riscv_wb_rd*.
- **Redirect latency:**
  - Event in cycle N with no stall → flush/pcsel asserted in cycle N+1.
  - With a stall → asserted in the cycle after the first stall-free cycle.
- **Back-to-back events:** the minimum spacing is 2 cycles, because the FIRE cycle blocks commits. The first event after FIRE is accepted in the cycle after FIRE.
- **Reset mid-operation:** reset asserted in WAIT or FIRE aborts the redirect. No flush is issued after reset deasserts.
- **Stall during FIRE:** has no effect; the pulse is never extended.

## Test plan
- **Source select:** NSRC = 5, valid, regwrite, rdaddr = 7, resultsrc = 2, src2 = 0xDEAD → next cycle rddata = 0xDEAD, rdaddr = 7, regwrite = 1, instret = 1. Repeat with iscsr = 1, csrout = 0x55 → rddata = 0x55.
- **x0 and out-of-range:** rdaddr = 0 → regwrite = 0 but instret still increments. resultsrc = 6 with NSRC = 5 → rddata = 0.
- **Trap without stall:** gototrap in cycle N → no write, instret unchanged; cycle N+1 flush = 1, pcsel = 01; cycle N+2 flush = 0, pcsel = 00. A valid instruction in cycle N+1 is not committed.
- **Return under stall:** returnfromtrap = 10 with icache_stall high for 3 cycles → busy = 1 and flush = 0 while stalled. One cycle after the stall drops: flush = 1, pcsel = 11. instret increments once.
- **Priority and wrap:** gototrap = 1 with returnfromtrap = 01 → pcsel = 01. Preload instret to 2^64−1 and commit → instret = 0.
- **Reset in WAIT:** assert rst_n low while in WAIT → all outputs are 0 immediately (asynchronously); no flush after deassert.
